// File: rtl/jtkcpu_div_if.sv
// jtkcpu_div_if: sequencer <-> divider handshake and operand/result bus
interface jtkcpu_div_if #(parameter int QW = 16, parameter int RW = 8);
    logic          start;
    logic [QW-1:0] dividend;
    logic [RW-1:0] divisor;
    logic [7:0]    cc_in;
    logic          busy;
    logic          done;
    logic [QW-1:0] quot;
    logic [RW-1:0] rem;
    logic [7:0]    cc_out;
    modport master(output start, dividend, divisor, cc_in, input busy, done, quot, rem, cc_out);
    modport slave(input start, dividend, divisor, cc_in, output busy, done, quot, rem, cc_out);
endinterface

// File: rtl/jtkcpu_div.sv
// jtkcpu_div: restoring shift-subtract divider for DIVX (X / B -> quotient X, remainder A)
module jtkcpu_div #(parameter int QW = 16, parameter int RW = 8) (
    input logic         rst,
    input logic         clk,
    input logic         cen,
    jtkcpu_div_if.slave io
);
    localparam int CW = $clog2(QW + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW:0]   part_q, part_d, shl;
    logic [QW-1:0] dq_q, dq_d, quot_q, quot_d;
    logic [RW-1:0] dvs_q, dvs_d, rem_q, rem_d;
    logic [7:0]    ccl_q, ccl_d, cc_q, cc_d;
    logic          busy_q, busy_d, done_q, done_d, ge;

    // upper condition-code bits pass through from the latched value
    function automatic logic [7:0] flags(input logic [QW-1:0] q, input logic v, input logic [7:0] c);
        return (c & 8'hF0) | {4'h0, q[QW-1], q == '0, v, q[7]};
    endfunction

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        part_d = part_q;
        dq_d   = dq_q;
        dvs_d  = dvs_q;
        ccl_d  = ccl_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        cc_d   = cc_q;
        busy_d = busy_q;
        done_d = 1'b0;
        shl    = {part_q[RW-1:0], dq_q[QW-1]};
        ge     = shl >= {1'b0, dvs_q};
        case (st_q)
            IDLE: if (io.start) begin
                dq_d   = io.dividend;
                dvs_d  = io.divisor;
                ccl_d  = io.cc_in;
                part_d = '0;
                busy_d = 1'b1;
                cnt_d  = io.divisor != '0 ? CW'(QW) : '0;
                st_d   = io.divisor != '0 ? RUN : FIN;
            end
            RUN: begin
                part_d = ge ? shl - {1'b0, dvs_q} : shl;
                dq_d   = {dq_q[QW-2:0], ge};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    quot_d = dq_d;
                    rem_d  = part_d[RW-1:0];
                    cc_d   = flags(dq_d, 1'b0, ccl_q);
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    st_d   = IDLE;
                end
            end
            FIN: begin
                quot_d = '1;
                rem_d  = dq_q[RW-1:0];
                cc_d   = flags('1, 1'b1, ccl_q);
                done_d = 1'b1;
                busy_d = 1'b0;
                st_d   = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            part_q <= '0;
            dq_q   <= '0;
            dvs_q  <= '0;
            ccl_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            cc_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (cen) begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            part_q <= part_d;
            dq_q   <= dq_d;
            dvs_q  <= dvs_d;
            ccl_q  <= ccl_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            cc_q   <= cc_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign io.busy   = busy_q;
    assign io.done   = done_q;
    assign io.quot   = quot_q;
    assign io.rem    = rem_q;
    assign io.cc_out = cc_q;
endmodule

// File: tb/tb_jtkcpu_div.sv
// tb_jtkcpu_div: randomized divider bench checked against plain integer division
module tb_jtkcpu_div;
    logic clk = 1'b0, rst = 1'b1, cen = 1'b0;
    int nvec = 0, nerr = 0;

    jtkcpu_div_if #(.QW(16), .RW(8)) io();
    jtkcpu_div #(.QW(16), .RW(8)) dut(.rst(rst), .clk(clk), .cen(cen), .io(io));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic c);
        cen = c;
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c,
                         output logic [15:0] q, output logic [7:0] r, output logic [7:0] f, output int lat);
        logic v;
        v   = (b == 0);
        q   = v ? 16'hFFFF : a / 16'(b);
        r   = v ? a[7:0] : 8'(a % 16'(b));
        lat = v ? 1 : 16;
        f   = (c & 8'hF0) | {4'h0, q[15], q == 16'h0, v, q[7]};
    endtask

    task automatic accept(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c);
        io.start = 1'b1;
        io.dividend = a;
        io.divisor = b;
        io.cc_in = c;
        tick(1);
        io.start = 1'b0;
        io.dividend = 16'($urandom);
        io.divisor = 8'($urandom);
        io.cc_in = 8'($urandom);
    endtask

    // mode 0: cen always high, 1: cen alternating, 2: cen random
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c,
                          input int mode, input int pre, input string tag);
        logic [15:0] eq;
        logic [7:0] er, ec;
        int lat, edges, cyc;
        logic c1;
        model(a, b, c, eq, er, ec, lat);
        accept(a, b, c);
        chk({tag, " busy"}, 32'(io.busy), 1);
        chk({tag, " done clr"}, 32'(io.done), 0);
        edges = 0;
        cyc = 0;
        while (!io.done && cyc < 200) begin
            c1 = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
            if (pre > 0 && edges == pre - 1 && c1) begin
                io.start = 1'b1;
                io.dividend = 16'h0001;
                io.divisor = 8'h01;
            end
            tick(c1);
            io.start = 1'b0;
            edges += int'(c1);
            cyc++;
        end
        chk({tag, " done"}, 32'(io.done), 1);
        chk({tag, " latency"}, 32'(edges), 32'(lat));
        chk({tag, " quot"}, 32'(io.quot), 32'(eq));
        chk({tag, " rem"}, 32'(io.rem), 32'(er));
        chk({tag, " cc"}, 32'(io.cc_out), 32'(ec));
        if (mode != 0) begin
            tick(0);
            chk({tag, " done hold"}, 32'(io.done), 1);
        end
        tick(1);
        chk({tag, " done pulse"}, 32'(io.done), 0);
        chk({tag, " quot hold"}, 32'(io.quot), 32'(eq));
    endtask

    initial begin
        int ndone, first, second;
        logic [15:0] a;
        logic [7:0] b;
        io.start = 1'b0;
        io.dividend = '0;
        io.divisor = '0;
        io.cc_in = '0;
        tick(0);
        tick(1);
        chk("rst busy", 32'(io.busy), 0);
        chk("rst done", 32'(io.done), 0);
        chk("rst quot", 32'(io.quot), 0);
        chk("rst rem", 32'(io.rem), 0);
        chk("rst cc", 32'(io.cc_out), 0);
        rst = 1'b0;
        tick(1);

        run_op(16'h03E8, 8'h07, 8'h00, 0, 0, "t1");
        run_op(16'hFFFF, 8'h01, 8'hF0, 0, 0, "t2");
        run_op(16'h0005, 8'h0A, 8'h00, 0, 0, "t3");
        run_op(16'h1234, 8'h00, 8'h00, 0, 0, "t3dz");
        run_op(16'h03E8, 8'h07, 8'h00, 1, 0, "t4");
        run_op(16'h03E8, 8'h07, 8'h00, 0, 5, "t5ign");

        accept(16'h03E8, 8'h07, 8'h00);
        repeat (8) tick(1);
        #2 rst = 1'b1;
        #1;
        chk("t5rst busy", 32'(io.busy), 0);
        chk("t5rst done", 32'(io.done), 0);
        chk("t5rst quot", 32'(io.quot), 0);
        chk("t5rst rem", 32'(io.rem), 0);
        #1 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            ndone += int'(io.done);
        end
        chk("t5rst no done", 32'(ndone), 0);

        io.start = 1'b1;
        io.dividend = 16'h03E8;
        io.divisor = 8'h07;
        io.cc_in = 8'h00;
        tick(1);
        ndone = 0;
        first = -1;
        second = -1;
        for (int i = 1; i <= 33; i++) begin
            tick(1);
            if (io.done) begin
                ndone++;
                if (first < 0) first = i; else second = i;
            end
        end
        io.start = 1'b0;
        chk("t6 count", 32'(ndone), 2);
        chk("t6 first", 32'(first), 16);
        chk("t6 second", 32'(second), 33);
        chk("t6 quot", 32'(io.quot), 32'h008E);
        tick(1);
        chk("t6 pulse", 32'(io.done), 0);

        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = $urandom_range(0, 4) == 0 ? 8'h00 : 8'($urandom);
            run_op(a, b, 8'($urandom), $urandom_range(0, 2), 0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
